mem_access_pipe: RTL and testbench
==================================

// Module: mem_access_pipe
// PURPOSE
//  DLX MEM stage, successor to the plain EX/MEM->WB register. Issues loads/stores to data memory
//  over a req/ack handshake with wait states, aligns store data/byte enables, aligns and
//  sign/zero-extends load data, and registers results toward WB with stall and flush support.
// PARAMETERS
//  DATA_WIDTH      32  datapath/memory word width; 32 or 64; BE_W = DATA_WIDTH/8
//  REG_ADDR_WIDTH  5   register-file address width
// PORTS
//  clk                     in   1           clock, rising edge
//  rst                     in   1           asynchronous reset, active-high
//  ex_valid_in             in   1           EX presents a valid op
//  mem_rd_in / mem_wr_in   in   1 / 1       load / store op (mutually exclusive)
//  mem_size_in             in   2           00 byte, 01 half, 10 word, 11 dword (64-bit only)
//  mem_signed_in           in   1           1 = sign-extend load
//  alu_data_in             in   DATA_WIDTH  ALU result / effective address
//  store_data_in           in   DATA_WIDTH  store data, LSB-justified
//  write_back_mux_sel_in   in   1           passed to WB
//  reg_wr_en_in            in   1           passed to WB
//  reg_wr_addr_in          in   REG_ADDR_WIDTH  passed to WB
//  flush_in                in   1           kill op in this stage
//  stall_out               out  1           upstream must hold inputs
//  dmem_req/dmem_we        out  1 / 1       memory request / write
//  dmem_addr               out  DATA_WIDTH  address, lane bits cleared
//  dmem_wdata              out  DATA_WIDTH  lane-replicated store data
//  dmem_be                 out  BE_W        byte enables
//  dmem_rdata              in   DATA_WIDTH  read data, valid with ack
//  dmem_ack                in   1           request complete
//  wb_valid_out            out  1           WB outputs hold a valid op
//  write_back_mux_sel_out, alu_data_out, reg_wr_en_out, reg_wr_addr_out  out  registered pass-through
//  mem_data_out            out  DATA_WIDTH  aligned/extended load data
//  misalign_out            out  1           misaligned access flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; dmem_req drops immediately (async), also mid-ACCESS.
//  - FSM IDLE: ex_valid_in & !mem op -> WB regs load inputs next edge (latency 1).
//    ex_valid_in & mem op -> latch op, go ACCESS; WB regs get bubble (wb_valid_out=0, reg_wr_en_out=0).
//    !ex_valid_in -> bubble.
//  - ACCESS: dmem_req=1, stall_out=1 (incl. ack cycle); outputs stable until ack.
//    dmem_ack -> WB regs load op (load: mem_data_out from dmem_rdata), go IDLE. Latency 2+wait states.
//  - dmem_ack while IDLE ignored. Next op accepted on the cycle after the ack edge.
//  - off = alu addr[log2(BE_W)-1:0]. Store: wdata = data replicated per size; be = byte 1<<off,
//    half 2'b11<<off, word 4'hF<<off, full all-ones.
//  - Load: rdata >> 8*off, truncate to size, sign- (mem_signed_in) or zero-extend to DATA_WIDTH.
//  - Misaligned: half off[0]!=0, word off[1:0]!=0, dword off!=0.
//  - flush_in in IDLE: input treated as bubble, no request. In ACCESS: request runs to ack
//    (bus not abandoned; store still writes), result discarded: wb_valid_out=0, reg_wr_en_out=0.
//  - Simultaneous flush_in & dmem_ack: discard result, go IDLE.
// CONFIGURATION
//  MEM_ACCESS_ALIGN_CHK_EN defined: misaligned mem op never issued; next edge WB regs load
//    bubble with misalign_out=1 for one cycle, reg_wr_en_out=0; FSM stays IDLE.
//  Undefined: no check; off bits used as-is (access wraps within word lanes); misalign_out tied 0.
// TESTING
//  1 ALU op alu=0x1234, wr_en=1, addr=7 -> next cycle wb_valid=1, alu_data_out=0x1234, no dmem_req.
//  2 LB signed addr=0x103, ack after 3 wait cycles, rdata=0x80FFFFFF -> mem_data_out=0xFFFFFF80;
//    stall_out high 4 cycles.
//  3 SH addr=0x102, data=0xABCD -> dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_addr=0x100, we=1.
//  4 LW in ACCESS, flush_in on ack cycle -> wb_valid_out=0, reg_wr_en_out=0, FSM IDLE.
//  5 rst pulsed mid-ACCESS -> dmem_req=0 immediately, all outputs 0, next op accepted after release.
//  6 ALIGN_CHK_EN, LW addr=0x101 -> no dmem_req, misalign_out=1 one cycle, reg_wr_en_out=0.

Source files
------------

// File: rtl/mem_access_pipe.sv
// DLX MEM stage: data-memory req/ack access with store lane alignment, load extraction/extension,
// and registered WB outputs. Optional misalignment trap: define MEM_ACCESS_ALIGN_CHK_EN.
module mem_access_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid_in,
  input  logic                      mem_rd_in,
  input  logic                      mem_wr_in,
  input  logic [1:0]                mem_size_in,
  input  logic                      mem_signed_in,
  input  logic [DATA_WIDTH-1:0]     alu_data_in,
  input  logic [DATA_WIDTH-1:0]     store_data_in,
  input  logic                      write_back_mux_sel_in,
  input  logic                      reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
  input  logic                      flush_in,
  output logic                      stall_out,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DATA_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  output logic [DATA_WIDTH/8-1:0]   dmem_be,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  input  logic                      dmem_ack,
  output logic                      wb_valid_out,
  output logic                      write_back_mux_sel_out,
  output logic [DATA_WIDTH-1:0]     alu_data_out,
  output logic                      reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
  output logic [DATA_WIDTH-1:0]     mem_data_out,
  output logic                      misalign_out
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                    r_state;
  logic                      r_rd;
  logic [1:0]                r_size;
  logic                      r_signed;
  logic [DATA_WIDTH-1:0]     r_alu;
  logic                      r_wbsel;
  logic                      r_wren;
  logic [REG_ADDR_WIDTH-1:0] r_waddr;
  logic                      r_flushed;

  logic                      r_req;
  logic                      r_we;
  logic [DATA_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [BE_W-1:0]           r_be;
  logic                      r_wb_valid;
  logic                      r_wb_sel;
  logic [DATA_WIDTH-1:0]     r_alu_out;
  logic                      r_reg_wr_en;
  logic [REG_ADDR_WIDTH-1:0] r_reg_wr_addr;
  logic [DATA_WIDTH-1:0]     r_mem_data;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
  logic                      r_misalign;
`endif

  logic [OFF_W-1:0]      w_off;
  logic                  w_mem_op;
  logic                  w_accept;
  logic                  w_bad;
  logic                  w_start;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [BE_W-1:0]       w_be;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_load;

  assign w_off    = alu_data_in[OFF_W-1:0];
  assign w_mem_op = mem_rd_in | mem_wr_in;
  assign w_accept = ex_valid_in & ~flush_in;

`ifdef MEM_ACCESS_ALIGN_CHK_EN
  logic w_misalign;
  always_comb begin
    w_misalign = 1'b0;
    case (mem_size_in)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = w_off[0];
      2'b10:   w_misalign = |w_off[1:0];
      default: w_misalign = |w_off;
    endcase
  end
  assign w_bad = w_accept & w_mem_op & w_misalign;
`else
  assign w_bad = 1'b0;
`endif

  assign w_start = w_accept & w_mem_op & ~w_bad;

  // Store data is replicated across every lane so the byte enables alone select the target bytes.
  always_comb begin
    w_wdata = store_data_in;
    w_be    = '1;
    case (mem_size_in)
      2'b00: begin
        w_wdata = {(BE_W){store_data_in[7:0]}};
        w_be    = BE_W'(1) << w_off;
      end
      2'b01: begin
        w_wdata = {(BE_W/2){store_data_in[15:0]}};
        w_be    = BE_W'(3) << w_off;
      end
      2'b10: begin
        w_wdata = {(BE_W/4){store_data_in[31:0]}};
        w_be    = BE_W'(4'hF) << w_off;
      end
      default: begin
        w_wdata = store_data_in;
        w_be    = '1;
      end
    endcase
  end

  assign w_shifted = dmem_rdata >> {r_alu[OFF_W-1:0], 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (r_size)
      2'b00: begin
        if (r_signed) w_load = DATA_WIDTH'($signed(w_shifted[7:0]));
        else          w_load = DATA_WIDTH'(w_shifted[7:0]);
      end
      2'b01: begin
        if (r_signed) w_load = DATA_WIDTH'($signed(w_shifted[15:0]));
        else          w_load = DATA_WIDTH'(w_shifted[15:0]);
      end
      2'b10: begin
        if (r_signed) w_load = DATA_WIDTH'($signed(w_shifted[31:0]));
        else          w_load = DATA_WIDTH'(w_shifted[31:0]);
      end
      default: w_load = w_shifted;
    endcase
  end

  // A flush seen at any point of an access is remembered so the completed result is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rd          <= 1'b0;
      r_size        <= 2'b00;
      r_signed      <= 1'b0;
      r_alu         <= '0;
      r_wbsel       <= 1'b0;
      r_wren        <= 1'b0;
      r_waddr       <= '0;
      r_flushed     <= 1'b0;
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_be          <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_sel      <= 1'b0;
      r_alu_out     <= '0;
      r_reg_wr_en   <= 1'b0;
      r_reg_wr_addr <= '0;
      r_mem_data    <= '0;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef MEM_ACCESS_ALIGN_CHK_EN
          r_misalign <= w_bad;
`endif
          if (w_accept && !w_mem_op) begin
            r_wb_valid    <= 1'b1;
            r_wb_sel      <= write_back_mux_sel_in;
            r_alu_out     <= alu_data_in;
            r_reg_wr_en   <= reg_wr_en_in;
            r_reg_wr_addr <= reg_wr_addr_in;
          end else begin
            r_wb_valid    <= 1'b0;
            r_wb_sel      <= 1'b0;
            r_alu_out     <= '0;
            r_reg_wr_en   <= 1'b0;
            r_reg_wr_addr <= '0;
          end
          r_mem_data <= '0;
          if (w_start) begin
            r_rd      <= mem_rd_in;
            r_size    <= mem_size_in;
            r_signed  <= mem_signed_in;
            r_alu     <= alu_data_in;
            r_wbsel   <= write_back_mux_sel_in;
            r_wren    <= reg_wr_en_in;
            r_waddr   <= reg_wr_addr_in;
            r_flushed <= 1'b0;
            r_req     <= 1'b1;
            r_we      <= mem_wr_in;
            r_addr    <= {alu_data_in[DATA_WIDTH-1:OFF_W], OFF_W'(0)};
            r_wdata   <= w_wdata;
            r_be      <= w_be;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (flush_in) r_flushed <= 1'b1;
          if (dmem_ack) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_flushed <= 1'b0;
            r_state   <= S_IDLE;
            if (r_flushed || flush_in) begin
              r_wb_valid    <= 1'b0;
              r_wb_sel      <= 1'b0;
              r_alu_out     <= '0;
              r_reg_wr_en   <= 1'b0;
              r_reg_wr_addr <= '0;
              r_mem_data    <= '0;
            end else begin
              r_wb_valid    <= 1'b1;
              r_wb_sel      <= r_wbsel;
              r_alu_out     <= r_alu;
              r_reg_wr_en   <= r_wren;
              r_reg_wr_addr <= r_waddr;
              r_mem_data    <= r_rd ? w_load : '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_out              = (r_state == S_ACCESS);
  assign dmem_req               = r_req;
  assign dmem_we                = r_we;
  assign dmem_addr              = r_addr;
  assign dmem_wdata             = r_wdata;
  assign dmem_be                = r_be;
  assign wb_valid_out           = r_wb_valid;
  assign write_back_mux_sel_out = r_wb_sel;
  assign alu_data_out           = r_alu_out;
  assign reg_wr_en_out          = r_reg_wr_en;
  assign reg_wr_addr_out        = r_reg_wr_addr;
  assign mem_data_out           = r_mem_data;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
  assign misalign_out           = r_misalign;
`else
  assign misalign_out           = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_pipe.sv
// Directed bench for mem_access_pipe (32-bit): table of load/store transactions plus
// hand-written sequences for flush, reset mid-access, idle ack and misalignment.
module tb_mem_access_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_in, mem_rd_in, mem_wr_in, mem_signed_in;
  logic [1:0]  mem_size_in;
  logic [31:0] alu_data_in, store_data_in;
  logic        write_back_mux_sel_in, reg_wr_en_in;
  logic [4:0]  reg_wr_addr_in;
  logic        flush_in;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        wb_valid_out, write_back_mux_sel_out, reg_wr_en_out, misalign_out;
  logic [31:0] alu_data_out, mem_data_out;
  logic [4:0]  reg_wr_addr_out;

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] alu;
    logic [31:0] sdata;
    int          waits;
    logic [31:0] rdata;
    logic        wbsel;
    logic        wren;
    logic [4:0]  waddr;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expBe;
    logic [31:0] expMem;
  } vec_t;

  vec_t vecs[8];
  vec_t misVec;

  mem_access_pipe #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_in(ex_valid_in), .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
    .mem_size_in(mem_size_in), .mem_signed_in(mem_signed_in),
    .alu_data_in(alu_data_in), .store_data_in(store_data_in),
    .write_back_mux_sel_in(write_back_mux_sel_in), .reg_wr_en_in(reg_wr_en_in),
    .reg_wr_addr_in(reg_wr_addr_in), .flush_in(flush_in), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wb_valid_out(wb_valid_out),
    .write_back_mux_sel_out(write_back_mux_sel_out), .alu_data_out(alu_data_out),
    .reg_wr_en_out(reg_wr_en_out), .reg_wr_addr_out(reg_wr_addr_out),
    .mem_data_out(mem_data_out), .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    ex_valid_in = 1'b0; mem_rd_in = 1'b0; mem_wr_in = 1'b0; mem_size_in = 2'b00;
    mem_signed_in = 1'b0; alu_data_in = '0; store_data_in = '0;
    write_back_mux_sel_in = 1'b0; reg_wr_en_in = 1'b0; reg_wr_addr_in = '0;
    flush_in = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic driveAlu(input logic [31:0] alu, input logic [4:0] waddr);
    ex_valid_in = 1'b1; mem_rd_in = 1'b0; mem_wr_in = 1'b0;
    alu_data_in = alu; reg_wr_en_in = 1'b1; reg_wr_addr_in = waddr;
    write_back_mux_sel_in = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int stallCycles;
    ex_valid_in = 1'b1; mem_rd_in = v.rd; mem_wr_in = v.wr; mem_size_in = v.size;
    mem_signed_in = v.sgn; alu_data_in = v.alu; store_data_in = v.sdata;
    write_back_mux_sel_in = v.wbsel; reg_wr_en_in = v.wren; reg_wr_addr_in = v.waddr;
    checkOutput({tag, "_stall_accept"}, 32'(stall_out), 32'd0);
    step();
    idleInputs();
    checkOutput({tag, "_req"}, 32'(dmem_req), 32'd1);
    checkOutput({tag, "_we"}, 32'(dmem_we), 32'(v.wr));
    checkOutput({tag, "_addr"}, dmem_addr, v.expAddr);
    checkOutput({tag, "_wdata"}, dmem_wdata, v.expWdata);
    checkOutput({tag, "_be"}, 32'(dmem_be), 32'(v.expBe));
    checkOutput({tag, "_wb_bubble"}, 32'(wb_valid_out), 32'd0);
    stallCycles = 0;
    for (int i = 0; i < v.waits; i++) begin
      if (stall_out) stallCycles++;
      step();
    end
    checkOutput({tag, "_addr_hold"}, dmem_addr, v.expAddr);
    dmem_ack = 1'b1;
    dmem_rdata = v.rdata;
    if (stall_out) stallCycles++;
    step();
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    checkOutput({tag, "_stall_cycles"}, 32'(stallCycles), 32'(v.waits + 1));
    checkOutput({tag, "_wb_valid"}, 32'(wb_valid_out), 32'd1);
    checkOutput({tag, "_mem_data"}, mem_data_out, v.expMem);
    checkOutput({tag, "_alu_out"}, alu_data_out, v.alu);
    checkOutput({tag, "_wr_en"}, 32'(reg_wr_en_out), 32'(v.wren));
    checkOutput({tag, "_wr_addr"}, 32'(reg_wr_addr_out), 32'(v.waddr));
    checkOutput({tag, "_wbsel"}, 32'(write_back_mux_sel_out), 32'(v.wbsel));
    checkOutput({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
    checkOutput({tag, "_stall_done"}, 32'(stall_out), 32'd0);
  endtask

  initial begin
    //            rd    wr    size   sgn   alu         sdata         w  rdata         wbsel wren  waddr  addr        wdata         be       mem
    vecs[0] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        3, 32'h80FFFFFF, 1'b1, 1'b1, 5'd3,  32'h100, 32'h0,        4'b1000, 32'hFFFFFF80};
    vecs[1] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 0, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd0,  32'h100, 32'hABCDABCD, 4'b1100, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0,        1, 32'h123480AB, 1'b1, 1'b1, 5'd9,  32'h100, 32'h0,        4'b0010, 32'h00000080};
    vecs[3] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h202, 32'h0,        1, 32'h80015555, 1'b1, 1'b1, 5'd10, 32'h200, 32'h0,        4'b1100, 32'hFFFF8001};
    vecs[4] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h200, 32'h0,        0, 32'h1234F00D, 1'b1, 1'b1, 5'd11, 32'h200, 32'h0,        4'b0011, 32'h0000F00D};
    vecs[5] = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h300, 32'h0,        2, 32'hDEADBEEF, 1'b1, 1'b1, 5'd12, 32'h300, 32'h0,        4'b1111, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h401, 32'h1234565A, 2, 32'h0,        1'b0, 1'b0, 5'd0,  32'h400, 32'h5A5A5A5A, 4'b0010, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h404, 32'hCAFEF00D, 1, 32'h0,        1'b0, 1'b0, 5'd0,  32'h404, 32'hCAFEF00D, 4'b1111, 32'h0};
    misVec  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0,        1, 32'h11223344, 1'b1, 1'b1, 5'd4,  32'h100, 32'h0,        4'b1110, 32'h00112233};

    rst = 1'b1;
    idleInputs();
    step();
    checkOutput("reset_wb_valid", 32'(wb_valid_out), 32'd0);
    checkOutput("reset_req", 32'(dmem_req), 32'd0);
    checkOutput("reset_stall", 32'(stall_out), 32'd0);
    checkOutput("reset_alu_out", alu_data_out, 32'd0);
    rst = 1'b0;
    step();

    driveAlu(32'h1234, 5'd7);
    step();
    idleInputs();
    checkOutput("alu_wb_valid", 32'(wb_valid_out), 32'd1);
    checkOutput("alu_data", alu_data_out, 32'h1234);
    checkOutput("alu_wr_en", 32'(reg_wr_en_out), 32'd1);
    checkOutput("alu_wr_addr", 32'(reg_wr_addr_out), 32'd7);
    checkOutput("alu_no_req", 32'(dmem_req), 32'd0);
    step();
    checkOutput("alu_bubble_after", 32'(wb_valid_out), 32'd0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Ack arriving with no access in flight must be ignored.
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    step();
    idleInputs();
    checkOutput("idle_ack_req", 32'(dmem_req), 32'd0);
    checkOutput("idle_ack_stall", 32'(stall_out), 32'd0);
    checkOutput("idle_ack_wb", 32'(wb_valid_out), 32'd0);

    ex_valid_in = 1'b1; mem_rd_in = 1'b1; mem_size_in = 2'b10; alu_data_in = 32'h700;
    reg_wr_en_in = 1'b1; flush_in = 1'b1;
    step();
    idleInputs();
    checkOutput("flush_idle_req", 32'(dmem_req), 32'd0);
    checkOutput("flush_idle_stall", 32'(stall_out), 32'd0);
    checkOutput("flush_idle_wb", 32'(wb_valid_out), 32'd0);

    ex_valid_in = 1'b1; mem_rd_in = 1'b1; mem_size_in = 2'b10; alu_data_in = 32'h600;
    reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd5;
    step();
    idleInputs();
    checkOutput("flush_ack_req", 32'(dmem_req), 32'd1);
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA; flush_in = 1'b1;
    step();
    idleInputs();
    checkOutput("flush_ack_wb", 32'(wb_valid_out), 32'd0);
    checkOutput("flush_ack_wr_en", 32'(reg_wr_en_out), 32'd0);
    checkOutput("flush_ack_stall", 32'(stall_out), 32'd0);
    checkOutput("flush_ack_req_drop", 32'(dmem_req), 32'd0);
    driveAlu(32'h77, 5'd2);
    step();
    idleInputs();
    checkOutput("flush_then_alu", alu_data_out, 32'h77);

    ex_valid_in = 1'b1; mem_wr_in = 1'b1; mem_size_in = 2'b10; alu_data_in = 32'h500;
    store_data_in = 32'h12345678;
    step();
    idleInputs();
    checkOutput("rst_mid_req_before", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_mid_stall", 32'(stall_out), 32'd0);
    checkOutput("rst_mid_be", 32'(dmem_be), 32'd0);
    checkOutput("rst_mid_addr", dmem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    driveAlu(32'h99, 5'd6);
    step();
    idleInputs();
    checkOutput("rst_release_alu_valid", 32'(wb_valid_out), 32'd1);
    checkOutput("rst_release_alu_data", alu_data_out, 32'h99);

`ifdef MEM_ACCESS_ALIGN_CHK_EN
    ex_valid_in = 1'b1; mem_rd_in = 1'b1; mem_size_in = 2'b10; alu_data_in = 32'h101;
    reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd4;
    step();
    idleInputs();
    checkOutput("mis_req", 32'(dmem_req), 32'd0);
    checkOutput("mis_flag", 32'(misalign_out), 32'd1);
    checkOutput("mis_wr_en", 32'(reg_wr_en_out), 32'd0);
    checkOutput("mis_stall", 32'(stall_out), 32'd0);
    step();
    checkOutput("mis_flag_clear", 32'(misalign_out), 32'd0);
`else
    applyStimulus(misVec, "mis_wrap");
    checkOutput("mis_flag_tied", 32'(misalign_out), 32'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
